bg_line_renderer: RTL

BG_LINE_RENDERER -- requirements
Module: bg_line_renderer

---
 rtl/bg_line_renderer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bg_line_renderer.sv
// Tile-based background line renderer: fetches one line of nametable/pattern data
// into a ping-pong line buffer while the other buffer is scanned out as RGB.
module bg_line_renderer #(
    parameter int TILE_COLS = 32,
    parameter int TILE_ROWS = 30,
    parameter int PIX_BITS  = 2
) (
    input  logic                  cpu_clk,
    input  logic                  rst_n,
    input  logic                  line_start_i,
    input  logic [7:0]            fetch_y_i,
    input  logic [7:0]            scroll_x_i,
    input  logic [7:0]            scroll_y_i,
    input  logic                  enable_i,
    input  logic                  visible_i,
    input  logic [7:0]            current_x_i,
    output logic [9:0]            ntbl_addr_o,
    input  logic [7:0]            ntbl_data_i,
    output logic [7:0]            pmb_addr_o,
    input  logic [8*PIX_BITS-1:0] pmb_data_i,
    input  logic [2:0]            color0_i,
    input  logic [2:0]            color1_i,
    output logic [PIX_BITS-1:0]   r_o,
    output logic [PIX_BITS-1:0]   g_o,
    output logic [PIX_BITS-1:0]   b_o,
    output logic                  busy_o,
    output logic                  overrun_o
);
    localparam int LINE_W  = TILE_COLS * 8;
    localparam int XW      = $clog2(LINE_W);
    localparam int CW      = $clog2(TILE_COLS);
    localparam int PB      = PIX_BITS;
    localparam int WORLD_H = TILE_ROWS * 8;

    typedef enum logic [1:0] {IDLE, NT, PM, WR} state_t;

    state_t        state, state_next;
    logic [CW-1:0] col;
    logic          buf_sel;      // index of the buffer being displayed
    logic [7:0]    scroll_x_q;
    logic [7:0]    world_y;
    logic          hflip_q;
    logic          cs_q;
    logic [9:0]    ntbl_q;
    logic [7:0]    pmb_q;

    logic [PB-1:0] pix_buf [2][LINE_W];
    logic          cs_buf  [2][TILE_COLS];

    logic [8:0]    y_sum;
    logic [7:0]    world_y_next;
    logic [9:0]    ntbl_cur;
    logic [2:0]    pmb_row;
    logic [7:0]    pmb_cur;
    logic [XW-1:0] disp_idx;
    logic [PB-1:0] disp_pix;
    logic          disp_cs;
    logic [2:0]    color;

    // Vertical wrap keeps world_y inside the nametable height.
    assign y_sum        = {1'b0, fetch_y_i} + {1'b0, scroll_y_i};
    assign world_y_next = (y_sum >= 9'(WORLD_H)) ? 8'(y_sum - 9'(WORLD_H)) : y_sum[7:0];

    assign ntbl_cur = 10'({world_y[7:3], col});
    assign pmb_row  = ntbl_data_i[5] ? ~world_y[2:0] : world_y[2:0];
    assign pmb_cur  = {ntbl_data_i[4:0], pmb_row};

    assign ntbl_addr_o = (state == NT) ? ntbl_cur : ntbl_q;
    assign pmb_addr_o  = (state == PM) ? pmb_cur : pmb_q;
    assign busy_o      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = IDLE;
            NT:   state_next = PM;
            PM:   state_next = WR;
            WR:   state_next = (col == CW'(TILE_COLS - 1)) ? IDLE : NT;
            default: state_next = IDLE;
        endcase
        if (line_start_i) state_next = NT;
    end

    assign disp_idx = XW'(current_x_i + scroll_x_q);
    assign disp_pix = pix_buf[buf_sel][disp_idx];
    assign disp_cs  = cs_buf[buf_sel][disp_idx[XW-1:3]];
    assign color    = disp_cs ? color1_i : color0_i;

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            buf_sel    <= 1'b0;
            scroll_x_q <= '0;
            world_y    <= '0;
            hflip_q    <= 1'b0;
            cs_q       <= 1'b0;
            ntbl_q     <= '0;
            pmb_q      <= '0;
            overrun_o  <= 1'b0;
            r_o        <= '0;
            g_o        <= '0;
            b_o        <= '0;
        end else begin
            state <= state_next;
            if (state == NT) ntbl_q <= ntbl_cur;
            if (state == PM) begin
                pmb_q   <= pmb_cur;
                hflip_q <= ntbl_data_i[6];
                cs_q    <= ntbl_data_i[7];
            end
            // A new line always wins; a fill still in flight is abandoned.
            if (line_start_i) begin
                buf_sel    <= ~buf_sel;
                scroll_x_q <= scroll_x_i;
                world_y    <= world_y_next;
                col        <= '0;
                if (state != IDLE) overrun_o <= 1'b1;
            end else if (state == WR) begin
                col <= col + 1'b1;
            end
            if (visible_i && enable_i) begin
                r_o <= disp_pix & {PB{color[2]}};
                g_o <= disp_pix & {PB{color[1]}};
                b_o <= disp_pix & {PB{color[0]}};
            end else begin
                r_o <= '0;
                g_o <= '0;
                b_o <= '0;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (state == WR && !line_start_i) begin
            for (int k = 0; k < 8; k++) begin
                pix_buf[~buf_sel][{col, 3'(k)}] <= hflip_q ? pmb_data_i[k*PB +: PB]
                                                           : pmb_data_i[(7-k)*PB +: PB];
            end
            cs_buf[~buf_sel][col] <= cs_q;
        end
    end
endmodule
